// File: rtl/fht_seq.sv
// 8-point Fast Hadamard Transform sequencer: load 8 samples, 12 shared-butterfly steps, stream 8 coefficients.
// Optional FHT_SCALE_EN: output coefficients are arithmetically shifted right by 3 (normalised by 1/8).
module fht_seq #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW+2:0]   out_data,
    output logic            out_last,
    output logic            busy,
    output logic [1:0]      dbg_state_o
);

    localparam int OW = DW + 3;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits on ready, and out_data/out_last hold while out_valid=1 and out_ready=0.
    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_COMP   = 2'd1,
        S_UNLOAD = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             idx_q, idx_d;
    logic [3:0]             step_q, step_d;
    logic signed [OW-1:0]   m_q [8];
    logic signed [OW-1:0]   m_d [8];

    logic [1:0]             stage;
    logic [1:0]             pair_j;
    logic [2:0]             a_idx, b_idx;
    logic signed [OW-1:0]   bf_sum, bf_diff;
    logic signed [OW-1:0]   sel_word;

    // Butterfly pair for step k: stage s=k/4, j=k%4, partner b = a + (1<<s).
    always_comb begin
        stage  = step_q[3:2];
        pair_j = step_q[1:0];
        case (stage)
            2'd0: begin
                a_idx = {pair_j, 1'b0};
                b_idx = {pair_j, 1'b1};
            end
            2'd1: begin
                a_idx = {pair_j[1], 1'b0, pair_j[0]};
                b_idx = {pair_j[1], 1'b1, pair_j[0]};
            end
            default: begin
                a_idx = {1'b0, pair_j};
                b_idx = {1'b1, pair_j};
            end
        endcase
        bf_sum  = m_q[a_idx] + m_q[b_idx];
        bf_diff = m_q[a_idx] - m_q[b_idx];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        step_d  = step_q;
        for (int i = 0; i < 8; i++) begin
            m_d[i] = m_q[i];
        end
        case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    m_d[idx_q] = {{3{in_data[DW-1]}}, in_data};
                    idx_d      = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = S_COMP;
                        step_d  = 4'd0;
                        idx_d   = 3'd0;
                    end
                end
            end
            S_COMP: begin
                m_d[a_idx] = bf_sum;
                m_d[b_idx] = bf_diff;
                step_d     = step_q + 4'd1;
                if (step_q == 4'd11) begin
                    state_d = S_UNLOAD;
                    step_d  = 4'd0;
                    idx_d   = 3'd0;
                end
            end
            S_UNLOAD: begin
                if (out_ready) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = S_LOAD;
                        idx_d   = 3'd0;
                    end
                end
            end
            default: begin
                state_d = S_LOAD;
                idx_d   = 3'd0;
                step_d  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_LOAD;
            idx_q   <= 3'd0;
            step_q  <= 4'd0;
            for (int i = 0; i < 8; i++) begin
                m_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            step_q  <= step_d;
            for (int i = 0; i < 8; i++) begin
                m_q[i] <= m_d[i];
            end
        end
    end

    // All outputs decode from registered state, so an asserted reset clears them at once.
    assign sel_word    = m_q[idx_q];
    assign in_ready    = (state_q == S_LOAD);
    assign out_valid   = (state_q == S_UNLOAD);
    assign busy        = (state_q != S_LOAD);
    assign out_last    = out_valid && (idx_q == 3'd7);
    assign dbg_state_o = state_q;

`ifdef FHT_SCALE_EN
    assign out_data = out_valid ? (sel_word >>> 3) : '0;
`else
    assign out_data = out_valid ? sel_word : '0;
`endif

endmodule

// File: tb/tb_fht_seq.sv
// Directed bench for fht_seq: hand-computed Hadamard frames, backpressure, load gaps and mid-transform reset.
module tb_fht_seq;

    localparam int DW = 8;
    localparam int OW = DW + 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic            out_valid;
    logic            out_ready;
    logic [OW-1:0]   out_data;
    logic            out_last;
    logic            busy;
    logic [1:0]      dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [OW-1:0]         exp_q[$];
    logic signed [DW-1:0]  x_v [8];
    int                    exp_v [8];

    always #5 clk = ~clk;

    fht_seq #(.DW(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sdata();
        return int'($signed(out_data));
    endfunction

    task automatic push_exp(input int v);
        int e;
        e = v;
`ifdef FHT_SCALE_EN
        e = e >>> 3;
`endif
        exp_q.push_back(OW'(e));
    endtask

    // Loads x_v, checks latency, then unloads against exp_v; abort_step>=0 resets mid-transform instead.
    task automatic run_frame(input string name, input int gaps, input int rand_rdy,
                             input int hold, input int abort_step);
        int n;
        int k;
        int guard;
        int stall;
        int prev_data;
        int prev_last;
        logic [OW-1:0] e;
        for (int i = 0; i < 8; i++) push_exp(exp_v[i]);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (gaps != 0) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                end
            end
            check({name, " in_ready_load"}, int'(in_ready), 1);
            in_valid = 1'b1;
            in_data  = x_v[i];
            @(posedge clk);
        end
        if (abort_step >= 0) begin
            in_valid = 1'b0;
            repeat (abort_step) @(posedge clk);
            #2 reset = 1'b0;
            #1;
            check({name, " abort_busy"}, int'(busy), 0);
            check({name, " abort_out_valid"}, int'(out_valid), 0);
            check({name, " abort_out_data"}, sdata(), 0);
            check({name, " abort_in_ready"}, int'(in_ready), 1);
            @(negedge clk);
            reset = 1'b1;
            exp_q.delete();
            return;
        end
        n = 0;
        while (n < 40 && out_valid !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                in_valid = hold[0];
                in_data  = 8'h63;
            end
            if (out_valid !== 1'b1) begin
                check({name, " comp_busy"}, int'(busy), 1);
                check({name, " comp_out_data"}, sdata(), 0);
            end
        end
        check({name, " latency"}, n, 13);
        if (out_valid !== 1'b1) begin
            exp_q.delete();
            in_valid = 1'b0;
            return;
        end
        k = 0;
        guard = 0;
        stall = 0;
        prev_data = 0;
        prev_last = 0;
        while (k < 8 && guard < 200) begin
            guard++;
            out_ready = (rand_rdy != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            check({name, " unload_in_ready"}, int'(in_ready), 0);
            check({name, " unload_out_valid"}, int'(out_valid), 1);
            if (stall != 0) begin
                check({name, " stall_data"}, sdata(), prev_data);
                check({name, " stall_last"}, int'(out_last), prev_last);
            end
            if (out_ready) begin
                e = exp_q.pop_front();
                check($sformatf("%s X%0d", name, k), sdata(), int'($signed(e)));
                check($sformatf("%s last%0d", name, k), int'(out_last), (k == 7) ? 1 : 0);
                k++;
                stall = 0;
            end else begin
                stall = 1;
                prev_data = sdata();
                prev_last = int'(out_last);
            end
            @(posedge clk);
            @(negedge clk);
        end
        check({name, " unload_count"}, k, 8);
        check({name, " post_in_ready"}, int'(in_ready), 1);
        check({name, " post_out_valid"}, int'(out_valid), 0);
        check({name, " post_busy"}, int'(busy), 0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #1;
        check("rst in_ready", int'(in_ready), 1);
        check("rst out_valid", int'(out_valid), 0);
        check("rst out_data", sdata(), 0);
        check("rst out_last", int'(out_last), 0);
        check("rst busy", int'(busy), 0);
        check("rst state", int'(dbg_state), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        x_v = '{1, 1, 1, 1, 1, 1, 1, 1};
        exp_v = '{8, 0, 0, 0, 0, 0, 0, 0};
        run_frame("ones", 0, 0, 0, -1);

        x_v = '{1, 0, 0, 0, 0, 0, 0, 0};
        exp_v = '{1, 1, 1, 1, 1, 1, 1, 1};
        run_frame("impulse", 0, 0, 0, -1);

        x_v = '{1, -1, 1, -1, 1, -1, 1, -1};
        exp_v = '{0, 8, 0, 0, 0, 0, 0, 0};
        run_frame("alt", 0, 0, 0, -1);

        x_v = '{-128, -128, -128, -128, -128, -128, -128, -128};
        exp_v = '{-1024, 0, 0, 0, 0, 0, 0, 0};
        run_frame("extreme", 0, 0, 0, -1);

        x_v = '{-1, 0, 0, 0, 0, 0, 0, 0};
        exp_v = '{-1, -1, -1, -1, -1, -1, -1, -1};
        run_frame("neg_impulse", 0, 0, 0, -1);

        x_v = '{1, 2, 3, 4, 5, 6, 7, 8};
        exp_v = '{36, -4, -8, 0, -16, 0, 0, 0};
        run_frame("ramp", 0, 0, 0, -1);

        x_v = '{1, -1, 1, -1, 1, -1, 1, -1};
        exp_v = '{0, 8, 0, 0, 0, 0, 0, 0};
        run_frame("alt_bp", 0, 1, 1, -1);
        run_frame("alt_gaps", 1, 1, 0, -1);

        x_v = '{5, 5, 5, 5, 5, 5, 5, 5};
        exp_v = '{40, 0, 0, 0, 0, 0, 0, 0};
        run_frame("abort", 0, 0, 0, 5);

        x_v = '{1, 1, 1, 1, 1, 1, 1, 1};
        exp_v = '{8, 0, 0, 0, 0, 0, 0, 0};
        run_frame("after_abort", 0, 0, 0, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
